deconvolute_mc: RTL and testbench

DECONVOLUTE_MC -- requirements
Module: deconvolute_mc

---
 rtl/deconvolute_mc.sv | 180 ++++++++++++++++++
 tb/tb_deconvolute_mc.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/deconvolute_mc.sv
// deconvolute_mc: multi-channel baseline-limited pole-zero deconvolution, 5-strobe pipeline.
// Optional per-channel saturation event counters are built when DECONV_SAT_COUNT_EN is defined.
module deconvolute_mc #(
  parameter int N_CH         = 4,
  parameter int ADC_WIDTH    = 12,
  parameter int BL_EXTRA     = 2,
  parameter int FD_BITS      = 6,
  parameter int FN_BITS      = 6,
  parameter int FN_FRAC_BITS = 4
) (
  input  logic                                CLK,
  input  logic                                RST,
  input  logic                                ENABLE40,
  input  logic [N_CH*ADC_WIDTH-1:0]           ADC_IN,
  input  logic [N_CH*(ADC_WIDTH+BL_EXTRA)-1:0] BASELINE,
  input  logic [FD_BITS-1:0]                  FD,
  input  logic [FN_BITS-1:0]                  FN,
  input  logic                                BYPASS,
  input  logic                                SAT_CLR,
  output logic [N_CH*ADC_WIDTH-1:0]           ADC_OUT,
  output logic                                OUT_VALID,
  output logic [N_CH-1:0]                     SAT_FLAG,
  output logic [N_CH*16-1:0]                  SAT_COUNT
);

  localparam int BL_W = ADC_WIDTH + BL_EXTRA;
  localparam int C_W  = ADC_WIDTH + FD_BITS;
  localparam int D_W  = C_W + 1;
  localparam int P_W  = C_W + FN_BITS;
  localparam int R_W  = P_W + 1;
  localparam int SH   = FD_BITS + FN_FRAC_BITS;
  localparam logic [R_W-1:0] RND       = R_W'(1) << (SH - 1);
  localparam logic [R_W-1:0] OUT_MAX   = R_W'({ADC_WIDTH{1'b1}});
  localparam logic [2:0]     FILL_FULL = 3'd5;

  logic [ADC_WIDTH-1:0] l1_r    [N_CH];
  logic [ADC_WIDTH-1:0] l2_r    [N_CH];
  logic [ADC_WIDTH-1:0] l3_r    [N_CH];
  logic [ADC_WIDTH-1:0] l4_r    [N_CH];
  logic [ADC_WIDTH-1:0] lprev_r [N_CH];
  logic [D_W-1:0]       d2_r    [N_CH];
  logic [C_W-1:0]       c3_r    [N_CH];
  logic [P_W-1:0]       p4_r    [N_CH];
  logic [2:0]           fill_r;

  logic [ADC_WIDTH-1:0] l_s [N_CH];
  logic [D_W-1:0]       d_s [N_CH];
  logic [C_W-1:0]       c_s [N_CH];
  logic [P_W-1:0]       p_s [N_CH];
  logic [R_W-1:0]       r_s [N_CH];
  logic [ADC_WIDTH-1:0] o_s [N_CH];
  logic [N_CH-1:0]      sat_s;

  // Fractional baseline bits do not take part in the limiter.
  logic [N_CH*BL_EXTRA-1:0] bl_frac_unused_s;
  for (genvar g = 0; g < N_CH; g++) begin : g_frac
    assign bl_frac_unused_s[g*BL_EXTRA +: BL_EXTRA] = BASELINE[g*BL_W +: BL_EXTRA];
  end

  // Per-channel combinational datapath between pipeline registers
  always_comb begin
    sat_s = '0;
    for (int k = 0; k < N_CH; k++) begin
      l_s[k] = '0;
      d_s[k] = '0;
      c_s[k] = '0;
      p_s[k] = '0;
      r_s[k] = '0;
      o_s[k] = '0;
      if (ADC_IN[k*ADC_WIDTH +: ADC_WIDTH] > BASELINE[k*BL_W + BL_EXTRA +: ADC_WIDTH]) begin
        l_s[k] = ADC_IN[k*ADC_WIDTH +: ADC_WIDTH];
      end else begin
        l_s[k] = BASELINE[k*BL_W + BL_EXTRA +: ADC_WIDTH];
      end
      // Modular difference; the true value always fits D_W bits signed, so the MSB is the sign.
      d_s[k] = D_W'({l1_r[k], {FD_BITS{1'b0}}}) - D_W'(lprev_r[k]) * D_W'(FD);
      if (d2_r[k][D_W-1]) begin
        c_s[k] = '0;
      end else begin
        c_s[k] = d2_r[k][C_W-1:0];
      end
      p_s[k] = P_W'(c3_r[k]) * P_W'(FN);
      r_s[k] = (R_W'(p4_r[k]) + RND) >> SH;
      if (BYPASS) begin
        o_s[k] = l4_r[k];
      end else if (r_s[k] > OUT_MAX) begin
        o_s[k]   = '1;
        sat_s[k] = ENABLE40;
      end else begin
        o_s[k] = r_s[k][ADC_WIDTH-1:0];
      end
    end
  end

  // Strobe-gated pipeline advance, previous-sample tracking and output register
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < N_CH; k++) begin
        l1_r[k]    <= '0;
        l2_r[k]    <= '0;
        l3_r[k]    <= '0;
        l4_r[k]    <= '0;
        lprev_r[k] <= '0;
        d2_r[k]    <= '0;
        c3_r[k]    <= '0;
        p4_r[k]    <= '0;
      end
      fill_r    <= 3'd0;
      ADC_OUT   <= '0;
      OUT_VALID <= 1'b0;
    end else if (ENABLE40) begin
      for (int k = 0; k < N_CH; k++) begin
        l1_r[k]    <= l_s[k];
        lprev_r[k] <= l1_r[k];
        d2_r[k]    <= d_s[k];
        l2_r[k]    <= l1_r[k];
        c3_r[k]    <= c_s[k];
        l3_r[k]    <= l2_r[k];
        p4_r[k]    <= p_s[k];
        l4_r[k]    <= l3_r[k];
        ADC_OUT[k*ADC_WIDTH +: ADC_WIDTH] <= o_s[k];
      end
      if (fill_r != FILL_FULL) begin
        fill_r <= fill_r + 3'd1;
      end else begin
        fill_r <= fill_r;
      end
      OUT_VALID <= (fill_r >= 3'd4);
    end else begin
      OUT_VALID <= 1'b0;
    end
  end

  // Sticky saturation flags; an event on the clearing edge still sets the flag
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      SAT_FLAG <= '0;
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (sat_s[k]) begin
          SAT_FLAG[k] <= 1'b1;
        end else if (SAT_CLR) begin
          SAT_FLAG[k] <= 1'b0;
        end else begin
          SAT_FLAG[k] <= SAT_FLAG[k];
        end
      end
    end
  end

`ifdef DECONV_SAT_COUNT_EN
  logic [15:0] cnt_r [N_CH];

  // Saturating per-channel event counters with synchronous clear
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      for (int k = 0; k < N_CH; k++) begin
        cnt_r[k] <= 16'd0;
      end
    end else begin
      for (int k = 0; k < N_CH; k++) begin
        if (SAT_CLR) begin
          cnt_r[k] <= sat_s[k] ? 16'd1 : 16'd0;
        end else if (sat_s[k] && (cnt_r[k] != 16'hFFFF)) begin
          cnt_r[k] <= cnt_r[k] + 16'd1;
        end else begin
          cnt_r[k] <= cnt_r[k];
        end
      end
    end
  end

  for (genvar g = 0; g < N_CH; g++) begin : g_cnt
    assign SAT_COUNT[g*16 +: 16] = cnt_r[g];
  end
`else
  assign SAT_COUNT = '0;
`endif

endmodule

// File: tb/tb_deconvolute_mc.sv
// Self-checking bench for deconvolute_mc (N_CH=2): directed table, corner sequences, random vs model.
module tb_deconvolute_mc;
  localparam int NC = 2;
  localparam int AW = 12;
  localparam int BW = 14;
`ifdef DECONV_SAT_COUNT_EN
  localparam int CNT_EN = 1;
`else
  localparam int CNT_EN = 0;
`endif

  logic CLK = 1'b0;
  logic RST, ENABLE40, BYPASS, SAT_CLR;
  logic [NC*AW-1:0] ADC_IN;
  logic [NC*BW-1:0] BASELINE;
  logic [5:0] FD, FN;
  logic [NC*AW-1:0] ADC_OUT;
  logic OUT_VALID;
  logic [NC-1:0] SAT_FLAG;
  logic [NC*16-1:0] SAT_COUNT;

  int total = 0;
  int bad = 0;

  deconvolute_mc #(.N_CH(NC)) dut (
    .CLK(CLK), .RST(RST), .ENABLE40(ENABLE40), .ADC_IN(ADC_IN), .BASELINE(BASELINE),
    .FD(FD), .FN(FN), .BYPASS(BYPASS), .SAT_CLR(SAT_CLR), .ADC_OUT(ADC_OUT),
    .OUT_VALID(OUT_VALID), .SAT_FLAG(SAT_FLAG), .SAT_COUNT(SAT_COUNT)
  );

  always #4 CLK = ~CLK;

  typedef struct {
    int a0; int a1; int bl; int fd; int fn; bit byp; int e0; int e1;
  } vec_t;

  task automatic chk(input string nm, input longint act, input longint exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic set_in(input int a0, input int a1, input int bl, input int fd, input int fn, input bit byp);
    ADC_IN   = {12'(a1), 12'(a0)};
    BASELINE = {14'(bl * 4), 14'(bl * 4)};
    FD       = 6'(fd);
    FN       = 6'(fn);
    BYPASS   = byp;
  endtask

  task automatic tick(input bit en);
    ENABLE40 = en;
    @(posedge CLK);
    #1;
  endtask

  task automatic strobes(input int n);
    repeat (n) tick(1'b1);
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_out"}, ADC_OUT, 0);
    chk({nm, "_valid"}, OUT_VALID, 0);
    chk({nm, "_flag"}, SAT_FLAG, 0);
    chk({nm, "_count"}, SAT_COUNT, 0);
  endtask

  task automatic do_reset();
    RST = 1'b1;
    ENABLE40 = 1'b0;
    SAT_CLR = 1'b0;
    @(posedge CLK);
    #1;
    RST = 1'b0;
  endtask

  // Deconvolution rules computed directly from the arithmetic definition.
  task automatic ref_calc(input longint l, input longint lp, input longint fd, input longint fn,
                          input bit byp, output longint o, output bit sat);
    longint d, r;
    d = l * 64 - lp * fd;
    if (d < 0) d = 0;
    r = (d * fn + 512) / 1024;
    sat = 1'b0;
    if (byp) o = l;
    else if (r > 4095) begin o = 4095; sat = 1'b1; end
    else o = r;
  endtask

  vec_t tbl[6];
  int hl [0:511][0:NC-1];
  int hfd [0:511];
  int hfn [0:511];
  bit hbyp [0:511];

  initial begin
    longint eo [NC];
    bit ev [NC];
    bit ef [NC];
    int ec [NC];
    int st, av [NC], bv [NC], fdv, fnv, lv;
    bit bypv, en, clr, evalid;

    tbl[0] = '{a0:1000, a1:30,   bl:50,  fd:0,  fn:16, byp:1'b0, e0:1000, e1:50};
    tbl[1] = '{a0:1000, a1:30,   bl:50,  fd:32, fn:16, byp:1'b0, e0:500,  e1:25};
    tbl[2] = '{a0:3,    a1:0,    bl:0,   fd:0,  fn:24, byp:1'b0, e0:5,    e1:0};
    tbl[3] = '{a0:1234, a1:50,   bl:100, fd:16, fn:20, byp:1'b0, e0:1157, e1:94};
    tbl[4] = '{a0:2000, a1:4095, bl:0,   fd:0,  fn:0,  byp:1'b1, e0:2000, e1:4095};
    tbl[5] = '{a0:4095, a1:4095, bl:0,   fd:63, fn:63, byp:1'b0, e0:252,  e1:252};

    set_in(0, 0, 0, 0, 0, 1'b0);
    do_reset();
    chk_zero("reset");

    // First sample reaches the output on the 5th strobe, with the first valid pulse.
    set_in(1000, 30, 50, 0, 16, 1'b0);
    for (int i = 1; i <= 5; i++) begin
      tick(1'b1);
      chk($sformatf("latency_valid_%0d", i), OUT_VALID, (i == 5) ? 1 : 0);
    end
    chk("latency_out0", ADC_OUT[AW-1:0], 1000);
    chk("latency_out1", ADC_OUT[2*AW-1:AW], 50);

    for (int i = 0; i < 6; i++) begin
      set_in(tbl[i].a0, tbl[i].a1, tbl[i].bl, tbl[i].fd, tbl[i].fn, tbl[i].byp);
      strobes(6);
      chk($sformatf("tbl%0d_out0", i), ADC_OUT[AW-1:0], tbl[i].e0);
      chk($sformatf("tbl%0d_out1", i), ADC_OUT[2*AW-1:AW], tbl[i].e1);
      chk($sformatf("tbl%0d_valid", i), OUT_VALID, 1);
    end

    // Output holds while the strobe is idle.
    set_in(1000, 1000, 0, 32, 16, 1'b0);
    strobes(6);
    chk("steady_out", ADC_OUT[AW-1:0], 500);
    set_in(3000, 7, 0, 0, 63, 1'b0);
    for (int i = 0; i < 10; i++) begin
      tick(1'b0);
      chk($sformatf("hold_valid_%0d", i), OUT_VALID, 0);
    end
    chk("hold_out", ADC_OUT, {12'd500, 12'd500});

    // Negative difference clamps to zero.
    set_in(4000, 4000, 0, 63, 16, 1'b0);
    strobes(6);
    set_in(100, 100, 0, 63, 16, 1'b0);
    strobes(5);
    chk("clamp_out", ADC_OUT, 0);
    tick(1'b1);
    chk("clamp_next", ADC_OUT[AW-1:0], 2);

    // Single saturation event on a step.
    set_in(0, 0, 0, 63, 63, 1'b0);
    strobes(6);
    SAT_CLR = 1'b1;
    tick(1'b0);
    SAT_CLR = 1'b0;
    chk("clr_flag", SAT_FLAG, 0);
    chk("clr_count", SAT_COUNT, 0);
    set_in(2000, 2000, 0, 63, 63, 1'b0);
    strobes(4);
    chk("presat_flag", SAT_FLAG, 0);
    tick(1'b1);
    chk("sat_out", ADC_OUT, {12'd4095, 12'd4095});
    chk("sat_flag", SAT_FLAG, 2'b11);
    chk("sat_count0", SAT_COUNT[15:0], CNT_EN);
    chk("sat_count1", SAT_COUNT[31:16], CNT_EN);
    tick(1'b1);
    chk("postsat_out", ADC_OUT[AW-1:0], 123);
    chk("postsat_count", SAT_COUNT[15:0], CNT_EN);

    // Clear on the same edge as an event: the event wins.
    set_in(0, 0, 0, 63, 63, 1'b0);
    strobes(6);
    set_in(2000, 2000, 0, 63, 63, 1'b0);
    strobes(4);
    SAT_CLR = 1'b1;
    tick(1'b1);
    SAT_CLR = 1'b0;
    chk("clrsame_flag", SAT_FLAG, 2'b11);
    chk("clrsame_count0", SAT_COUNT[15:0], CNT_EN);
    chk("clrsame_count1", SAT_COUNT[31:16], CNT_EN);

    // Asynchronous reset mid-stream; first sample afterwards sees Lprev = 0.
    set_in(1000, 1000, 0, 32, 16, 1'b0);
    strobes(6);
    #2;
    RST = 1'b1;
    #1;
    chk_zero("midreset");
    @(posedge CLK);
    #1;
    RST = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      tick(1'b1);
      chk($sformatf("rel_valid_%0d", i), OUT_VALID, (i == 5) ? 1 : 0);
    end
    chk("rel_out", ADC_OUT, {12'd1000, 12'd1000});

    // Bypass passes the limited input and never flags saturation.
    set_in(0, 0, 0, 63, 63, 1'b0);
    strobes(6);
    set_in(2000, 2000, 0, 63, 63, 1'b1);
    strobes(5);
    chk("byp_out", ADC_OUT, {12'd2000, 12'd2000});
    chk("byp_flag", SAT_FLAG, 0);
    chk("byp_count", SAT_COUNT, 0);

    // Randomized run against the reference model.
    do_reset();
    st = 0;
    fdv = 32; fnv = 16; bypv = 1'b0;
    for (int k = 0; k < NC; k++) begin eo[k] = 0; ef[k] = 0; ec[k] = 0; end
    for (int c = 0; c < 400; c++) begin
      en  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 24) == 0);
      if ($urandom_range(0, 9) == 0) fdv = $urandom_range(0, 63);
      if ($urandom_range(0, 9) == 0) fnv = $urandom_range(0, 63);
      if ($urandom_range(0, 19) == 0) bypv = ~bypv;
      for (int k = 0; k < NC; k++) begin
        av[k] = ($urandom_range(0, 3) == 0) ? $urandom_range(0, 200) : $urandom_range(0, 4095);
        bv[k] = $urandom_range(0, 16383);
        ADC_IN[k*AW +: AW]   = 12'(av[k]);
        BASELINE[k*BW +: BW] = 14'(bv[k]);
      end
      FD = 6'(fdv); FN = 6'(fnv); BYPASS = bypv; SAT_CLR = clr;
      tick(en);
      evalid = 1'b0;
      for (int k = 0; k < NC; k++) ev[k] = 1'b0;
      if (en) begin
        for (int k = 0; k < NC; k++) begin
          lv = bv[k] / 4;
          hl[st][k] = (av[k] > lv) ? av[k] : lv;
        end
        hfd[st] = fdv; hfn[st] = fnv; hbyp[st] = bypv;
        if (st >= 4) begin
          for (int k = 0; k < NC; k++)
            ref_calc(hl[st-4][k], (st >= 5) ? hl[st-5][k] : 0, hfd[st-3], hfn[st-1], hbyp[st], eo[k], ev[k]);
          evalid = 1'b1;
        end
        st++;
      end
      for (int k = 0; k < NC; k++) begin
        if (ev[k]) ef[k] = 1'b1;
        else if (clr) ef[k] = 1'b0;
        if (clr) ec[k] = ev[k] ? 1 : 0;
        else if (ev[k] && ec[k] < 65535) ec[k]++;
      end
      SAT_CLR = 1'b0;
      chk($sformatf("rnd%0d_valid", c), OUT_VALID, evalid);
      for (int k = 0; k < NC; k++) begin
        chk($sformatf("rnd%0d_out%0d", c, k), ADC_OUT[k*AW +: AW], eo[k]);
        chk($sformatf("rnd%0d_flag%0d", c, k), SAT_FLAG[k], ef[k]);
        chk($sformatf("rnd%0d_cnt%0d", c, k), SAT_COUNT[k*16 +: 16], ec[k] * CNT_EN);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
